core_lsu_ctrl: RTL and testbench
================================

CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req_valid  in  1  execute stage presents a memory op.
REQ-004 SHALL have port: req_ready  out  1  block can accept an op.
REQ-005 SHALL have port: req_load  in  1  1 = load (mem_ren), 0 = store (mem_wen).
REQ-006 SHALL have port: req_mem_type  in  3  decoded funct3 width/sign code.
REQ-007 SHALL have port: req_addr  in  32  byte address (ALU result).
REQ-008 SHALL have port: req_wdata  in  32  store data (rs2).
REQ-009 SHALL have port: req_rd  in  5  load destination register.
REQ-010 SHALL have port: bus_req / bus_we  out  1 / 1  bus request, write enable.
REQ-011 SHALL have port: bus_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-012 SHALL have port: bus_be / bus_wdata  out  4 / 32  byte enables, lane-aligned write data.
REQ-013 SHALL have port: bus_gnt / bus_rvalid / bus_err  in  1 / 1 / 1  grant, response valid, response error.
REQ-014 SHALL have port: bus_rdata  in  32  read data, valid with bus_rvalid.
REQ-015 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-016 SHALL have port: rsp_fault / rsp_cause  out  1 / 2  fault flag; cause 0 misaligned, 1 bus error, 2 illegal mem_type.
REQ-017 SHALL have port: rsp_wen / rsp_rd / rsp_data  out  1 / 5 / 32  register writeback for loads.

Function
REQ-018 SHALL implement FSM IDLE, REQ, RSP; req_ready = 1 only in IDLE; one op outstanding.
REQ-019 SHALL accept on req_valid & req_ready, capturing all req_* fields into registers.
REQ-020 SHALL accept legal codes only: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-021 SHALL treat the op as misaligned when halfword addr[0] = 1 or word addr[1:0] != 0.
REQ-022 SHALL, for an illegal or misaligned op, stay in IDLE, issue no bus_req, and pulse rsp_valid = 1, rsp_fault = 1 with the matching cause the next cycle.
REQ-023 SHALL, for a legal op, enter REQ the next cycle and assert bus_req with stable addr/we/be/wdata until bus_gnt is sampled high.
REQ-024 SHALL generate bus_be per op: byte 4'b0001 << addr[1:0]; half 4'b0011 << (2*addr[1]); word 4'b1111.
REQ-025 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-026 SHALL move REQ -> RSP on bus_gnt, deassert bus_req that same edge, and ignore bus_rvalid while in REQ or IDLE.
REQ-027 SHALL wait in RSP for bus_rvalid with no timeout, then return to IDLE and pulse rsp_valid the following cycle (req_ready = 1 in that same cycle).
REQ-028 SHALL extract load data from bus_rdata >> (8*addr[1:0]), then sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits.
REQ-029 SHALL set rsp_wen = 1 only for a load with no fault, with rsp_rd = captured rd; stores give rsp_wen = 0 and rsp_data = 0.
REQ-030 SHALL, on bus_rvalid & bus_err, return rsp_fault = 1, cause 1, rsp_wen = 0.
REQ-031 SHALL, on rd = 0 for a load, still pulse rsp_valid but drive rsp_wen = 0.
REQ-032 SHALL hold rsp_* outputs at 0 whenever rsp_valid = 0.

Reset
REQ-033 SHALL, while rst_n = 0, immediately force state IDLE and drive all outputs to 0, except req_ready = 1 once rst_n is released.
REQ-034 SHALL abandon any in-flight op on mid-operation reset and produce no rsp_valid for it; a late bus_rvalid after reset SHALL be ignored.

Verification
REQ-035 SHALL pass: LW to 0x100, gnt at cycle 1, rvalid at cycle 3 with rdata 0xDEADBEEF -> rsp_valid at cycle 4, rsp_wen = 1, rsp_data = 0xDEADBEEF.
REQ-036 SHALL pass: LB to 0x203 with rdata 0x80FFFFFF -> bus_addr 0x200, rsp_data 0xFFFFFF80; LBU gives 0x00000080.
REQ-037 SHALL pass: SH to 0x302 with wdata 0x1234ABCD -> bus_be 4'b1100, bus_wdata 0xABCDABCD, bus_we = 1, rsp_wen = 0.
REQ-038 SHALL pass: LW to 0x101 -> no bus_req, rsp_fault = 1, cause 0, next cycle; mem_type 011 -> cause 2.
REQ-039 SHALL pass: bus_gnt held low for 5 cycles -> bus_req and payload stable for all 5; rvalid with bus_err -> rsp_fault = 1, cause 1.
REQ-040 SHALL pass: rst_n low while in RSP -> bus_req = 0, state IDLE, following bus_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/core_lsu_ctrl.sv
// Load/store unit controller: validates one memory op at a time, drives a
// single-beat bus transaction, and returns an aligned, extended writeback.
module core_lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_mem_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause,
    output logic        rsp_wen,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state;
    logic        load_q;
    logic [2:0]  type_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;

    logic        legal;
    logic        misaligned;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Handshake: an op transfers on a rising edge where req_valid & req_ready;
    // req_ready is high only in IDLE (and out of reset), so at most one op is
    // outstanding. Bus side: bus_req holds with a stable payload until bus_gnt
    // is sampled high; the single response is the cycle bus_rvalid is high.
    assign req_ready = rst_n && (state == IDLE);
    assign dbg_state = state;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_nxt     = 4'b1111;
        wdata_nxt  = req_wdata;
        case (req_mem_type)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = req_load;
            default:                legal = 1'b0;
        endcase
        case (req_mem_type[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_nxt     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt  = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = |req_addr[1:0];
                be_nxt     = 4'b1111;
                wdata_nxt  = req_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by width/sign code.
    always_comb begin
        shifted = bus_rdata >> {addr_lo_q, 3'b000};
        case (type_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_q    <= 1'b0;
            type_q    <= 3'd0;
            addr_lo_q <= 2'd0;
            rd_q      <= 5'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_cause <= 2'd0;
            rsp_wen   <= 1'b0;
            rsp_rd    <= 5'd0;
            rsp_data  <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_cause <= 2'd0;
            rsp_wen   <= 1'b0;
            rsp_rd    <= 5'd0;
            rsp_data  <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        load_q    <= req_load;
                        type_q    <= req_mem_type;
                        addr_lo_q <= req_addr[1:0];
                        rd_q      <= req_rd;
                        if (!legal) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_cause <= 2'd2;
                        end else if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_cause <= 2'd0;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= ~req_load;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= be_nxt;
                            bus_wdata <= wdata_nxt;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= RSP;
                    end
                end
                RSP: begin
                    if (bus_rvalid) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        if (bus_err) begin
                            rsp_fault <= 1'b1;
                            rsp_cause <= 2'd1;
                        end else if (load_q) begin
                            rsp_wen  <= (rd_q != 5'd0);
                            rsp_rd   <= rd_q;
                            rsp_data <= load_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl: bus-side checks inline, responses checked
// by a monitor against an expected-response queue.
module tb_core_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic [2:0]  req_mem_type = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        rsp_valid, rsp_fault, rsp_wen;
    logic [1:0]  rsp_cause;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [40:0] exp_q[$];

    core_lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_mem_type(req_mem_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_err(bus_err), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
        .rsp_wen(rsp_wen), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] rsp(input logic f, input logic [1:0] c, input logic w,
                                        input logic [4:0] rd, input logic [31:0] d);
        return {f, c, w, rd, d};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [40:0] e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got %h expected none",
                         {rsp_fault, rsp_cause, rsp_wen, rsp_rd, rsp_data});
            end else begin
                e = exp_q.pop_front();
                chk("rsp_fields", {23'd0, rsp_fault, rsp_cause, rsp_wen, rsp_rd, rsp_data}, {23'd0, e});
            end
        end else begin
            chk("rsp_idle_zero", {23'd0, rsp_fault, rsp_cause, rsp_wen, rsp_rd, rsp_data}, 64'd0);
        end
    end

    // drivers: every task starts and ends 1 time unit after a rising edge
    task automatic issue(input logic ld, input logic [2:0] mt, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1;
        req_load = ld;
        req_mem_type = mt;
        req_addr = a;
        req_wdata = wd;
        req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic fault_op(input string nm, input logic ld, input logic [2:0] mt,
                            input logic [31:0] a, input logic [1:0] cause);
        exp_q.push_back(rsp(1'b1, cause, 1'b0, 5'd0, 32'd0));
        issue(ld, mt, a, 32'h5555_AAAA, 5'd3);
        @(negedge clk);
        chk({nm, "_no_bus_req"}, {63'd0, bus_req}, 64'd0);
        chk({nm, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({nm, "_ready"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic mem_op(input string nm, input logic ld, input logic [2:0] mt,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input int gnt_wait, input int rsp_wait,
                          input logic [31:0] rdata, input logic err, input logic [40:0] e_rsp);
        exp_q.push_back(e_rsp);
        issue(ld, mt, a, wd, rd);
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) bus_gnt = 1'b1;
            @(negedge clk);
            chk({nm, "_bus_req"}, {63'd0, bus_req}, 64'd1);
            chk({nm, "_bus_we"}, {63'd0, bus_we}, {63'd0, ~ld});
            chk({nm, "_bus_addr"}, {32'd0, bus_addr}, {32'd0, e_addr});
            chk({nm, "_bus_be"}, {60'd0, bus_be}, {60'd0, e_be});
            chk({nm, "_bus_wdata"}, {32'd0, bus_wdata}, {32'd0, e_wd});
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            chk({nm, "_req_dropped"}, {63'd0, bus_req}, 64'd0);
            chk({nm, "_early_rsp"}, {63'd0, rsp_valid}, 64'd0);
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b1;
        bus_rdata = rdata;
        bus_err = err;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        bus_err = 1'b0;
        bus_rdata = 32'd0;
        @(negedge clk);
        chk({nm, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({nm, "_ready"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        // reset
        #1 rst_n = 1'b0;
        #2;
        chk("reset_ready", {63'd0, req_ready}, 64'd0);
        chk("reset_bus_req", {63'd0, bus_req}, 64'd0);
        chk("reset_state", {62'd0, dbg_state}, 64'd0);
        chk("reset_bus_addr", {32'd0, bus_addr}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // LW 0x100: gnt cycle 1, rvalid cycle 3, rsp cycle 4
        mem_op("lw", 1'b1, 3'b010, 32'h100, 32'h0, 5'd5, 32'h100, 4'b1111, 32'h0,
               0, 1, 32'hDEAD_BEEF, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd5, 32'hDEAD_BEEF));
        mem_op("lb", 1'b1, 3'b000, 32'h203, 32'h0, 5'd7, 32'h200, 4'b1000, 32'h0,
               0, 1, 32'h80FF_FFFF, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd7, 32'hFFFF_FF80));
        mem_op("lbu", 1'b1, 3'b100, 32'h203, 32'h0, 5'd7, 32'h200, 4'b1000, 32'h0,
               0, 0, 32'h80FF_FFFF, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd7, 32'h0000_0080));
        mem_op("sh", 1'b0, 3'b001, 32'h302, 32'h1234_ABCD, 5'd9, 32'h300, 4'b1100,
               32'hABCD_ABCD, 1, 2, 32'hFFFF_FFFF, 1'b0, rsp(1'b0, 2'd0, 1'b0, 5'd0, 32'd0));
        mem_op("lh", 1'b1, 3'b001, 32'h102, 32'h0, 5'd12, 32'h100, 4'b1100, 32'h0,
               0, 0, 32'h8001_1234, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd12, 32'hFFFF_8001));
        mem_op("lhu", 1'b1, 3'b101, 32'h100, 32'h0, 5'd13, 32'h100, 4'b0011, 32'h0,
               2, 0, 32'h8001_9234, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd13, 32'h0000_9234));
        mem_op("lb_rd0", 1'b1, 3'b000, 32'h001, 32'h0, 5'd0, 32'h000, 4'b0010, 32'h0,
               0, 0, 32'h0000_7F00, 1'b0, rsp(1'b0, 2'd0, 1'b0, 5'd0, 32'h0000_007F));
        mem_op("sb", 1'b0, 3'b000, 32'h005, 32'h0000_00A5, 5'd1, 32'h004, 4'b0010,
               32'hA5A5_A5A5, 0, 1, 32'h0, 1'b0, rsp(1'b0, 2'd0, 1'b0, 5'd0, 32'd0));
        // grant withheld 5 cycles, then error response
        mem_op("sw_err", 1'b0, 3'b010, 32'h400, 32'hCAFE_F00D, 5'd2, 32'h400, 4'b1111,
               32'hCAFE_F00D, 5, 1, 32'h1234_5678, 1'b1, rsp(1'b1, 2'd1, 1'b0, 5'd0, 32'd0));
        mem_op("lw_err", 1'b1, 3'b010, 32'h404, 32'h0, 5'd4, 32'h404, 4'b1111, 32'h0,
               0, 0, 32'h1234_5678, 1'b1, rsp(1'b1, 2'd1, 1'b0, 5'd0, 32'd0));

        // faults
        fault_op("lw_mis", 1'b1, 3'b010, 32'h101, 2'd0);
        fault_op("ld_011", 1'b1, 3'b011, 32'h100, 2'd2);
        fault_op("lh_mis", 1'b1, 3'b001, 32'h001, 2'd0);
        fault_op("sh_mis", 1'b0, 3'b001, 32'h003, 2'd0);
        fault_op("st_100", 1'b0, 3'b100, 32'h000, 2'd2);
        fault_op("ld_110", 1'b1, 3'b110, 32'h000, 2'd2);
        // back-to-back: legal op right after a fault pulse
        mem_op("lw_after_fault", 1'b1, 3'b010, 32'h0000_0FFC, 32'h0, 5'd31, 32'h0000_0FFC,
               4'b1111, 32'h0, 0, 0, 32'h0102_0304, 1'b0, rsp(1'b0, 2'd0, 1'b1, 5'd31, 32'h0102_0304));

        // reset while waiting for the response
        issue(1'b1, 3'b010, 32'h500, 32'h0, 5'd6);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_rsp", {62'd0, dbg_state}, 64'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_req", {63'd0, bus_req}, 64'd0);
        chk("rst_mid_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid_no_rsp", {63'd0, rsp_valid}, 64'd0);
            chk("late_rvalid_idle", {62'd0, dbg_state}, 64'd0);
        end
        @(posedge clk); #1;

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
